mem_responder: RTL and testbench

- Target side of the byte-serial RAM bus driven by the memory controller: RWstate, RWaddr, WrtData, ReadData.
- Serves ordinary addresses from an on-chip byte RAM.
- Serves the IO window (RWaddr[17:16]==2'b11) from a small register file fronted by TX and RX byte FIFOs.
- Sits between the memory controller and the board UART/host interface. It can never stall the controller; the bus has no wait signal.

---
 rtl/mem_responder_pkg.sv | 25 ++
 rtl/mem_responder_sync_fifo.sv | 65 ++++++
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the byte-serial RAM bus target.
// Holds the IO window decode values, the status byte layout and a small decode helper.
package mem_responder_pkg;

  // RWaddr[17:16] value that selects the IO register window.
  localparam logic [1:0] IoSpace  = 2'b11;

  // IO register offsets, taken from RWaddr[3:0].
  localparam logic [3:0] IoRxTx   = 4'h0;
  localparam logic [3:0] IoStatus = 4'h4;
  localparam logic [3:0] IoClr    = 4'h8;

  // Status byte returned at IoStatus.
  typedef struct packed {
    logic [4:0] zero;
    logic       overflow;
    logic       tx_full;
    logic       rx_nonempty;
  } status_t;

  function automatic logic is_io(input logic [1:0] space);
    return space == IoSpace;
  endfunction

endpackage

// File: rtl/mem_responder_sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count.
// Ports: clk_i/rst_i (async active-high reset), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o shows the head entry), full_o, empty_o, count_o.
// A push while full is accepted only if a pop happens on the same edge.
// A pop while empty is ignored. Depth must be a power of two, at least 2.
module mem_responder_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because Depth is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_responder.sv
// Target side of the byte-serial RAM bus driven by the memory controller.
// Ordinary addresses hit an on-chip byte RAM; RWaddr[17:16]==2'b11 selects a small IO
// register file fronted by TX (to UART) and RX (from host) byte FIFOs.
// Ports: clk, rst (async active-high); RWstate (0 read / 1 write), RWaddr, WrtData,
// ReadData (registered, 1-cycle latency); tx_data/tx_valid/tx_ready UART side;
// rx_data/rx_valid/rx_ready host side; halted (sticky program-end flag).
// The bus has no wait signal, so every access completes in the cycle it is presented.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 17,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RWstate,
  input  logic [31:0] RWaddr,
  input  logic [7:0]  WrtData,
  output logic [7:0]  ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halted
);

  localparam int unsigned TxCntW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RxCntW = $clog2(RX_DEPTH) + 1;

  // Previous {RWstate, RWaddr}; invalid after reset so the first access always qualifies.
  logic [32:0] prev_q, prev_d;
  logic        prev_valid_q, prev_valid_d;
  logic [7:0]  read_data_q, read_data_d;
  logic        overflow_q, overflow_d;
  logic        halted_q, halted_d;

  logic [32:0] access;
  logic        qualify;
  logic        io;
  logic [3:0]  off;
  logic        io_rd_evt, io_wr_evt;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [TxCntW-1:0] tx_count;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [RxCntW-1:0] rx_count;
  logic [7:0]        rx_head;

  logic [7:0]            ram [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic [7:0]            ram_rdata;
  status_t               status;

  assign access  = {RWstate, RWaddr};
  // The controller idles with the address held, so IO side effects fire only on change.
  assign qualify = !prev_valid_q || (access != prev_q);
  assign io      = is_io(RWaddr[17:16]);
  assign off     = RWaddr[3:0];

  assign io_rd_evt = qualify && io && !RWstate;
  assign io_wr_evt = qualify && io && RWstate;

  assign tx_push  = io_wr_evt && (off == IoRxTx);
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = io_rd_evt && (off == IoRxTx) && !rx_empty;

  assign ram_idx   = RWaddr[RAM_ADDR_W-1:0];
  assign ram_rdata = ram[ram_idx];

  assign status = '{zero: 5'b0, overflow: overflow_q, tx_full: tx_full,
                    rx_nonempty: !rx_empty};

  mem_responder_sync_fifo #(
    .Width (8),
    .Depth (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (tx_push),
    .wdata_i (WrtData),
    .pop_i   (tx_pop),
    .rdata_o (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  mem_responder_sync_fifo #(
    .Width (8),
    .Depth (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rx_push),
    .wdata_i (rx_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  always_comb begin
    prev_d       = access;
    prev_valid_d = 1'b1;
    read_data_d  = read_data_q;
    overflow_d   = overflow_q;
    halted_d     = halted_q;

    if (!RWstate) begin
      if (!io) begin
        read_data_d = ram_rdata;
      end else begin
        case (off)
          IoRxTx: begin
            // Held RX reads keep the popped byte instead of re-reading the FIFO head.
            if (qualify) read_data_d = rx_empty ? 8'h00 : rx_head;
          end
          IoStatus: read_data_d = status;
          default:  read_data_d = 8'h00;
        endcase
      end
    end

    if (tx_push && tx_full && !tx_pop) overflow_d = 1'b1;
    if (io_wr_evt && (off == IoClr))    overflow_d = 1'b0;
    if (io_wr_evt && (off == IoStatus)) halted_d   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      read_data_q  <= 8'h00;
      overflow_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      read_data_q  <= read_data_d;
      overflow_q   <= overflow_d;
      halted_q     <= halted_d;
    end
  end

  // RAM writes are unqualified: rewriting the same byte while the address is held is harmless.
  always_ff @(posedge clk) begin
    if (RWstate && !io) ram[ram_idx] <= WrtData;
  end

  assign ReadData = read_data_q;
  assign halted   = halted_q;

  tx_count_bound: assert property (@(posedge clk) disable iff (rst)
    tx_count <= TxCntW'(TX_DEPTH));
  rx_count_bound: assert property (@(posedge clk) disable iff (rst)
    rx_count <= RxCntW'(RX_DEPTH));

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        RWstate;
  logic [31:0] RWaddr;
  logic [7:0]  WrtData;
  logic [7:0]  ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  mem_responder u_dut (
    .clk      (clk),
    .rst      (rst),
    .RWstate  (RWstate),
    .RWaddr   (RWaddr),
    .WrtData  (WrtData),
    .ReadData (ReadData),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic st, input logic [31:0] a, input logic [7:0] d);
    RWstate = st;
    RWaddr  = a;
    WrtData = d;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    RWstate  = 1'b0;
    RWaddr   = 32'h0;
    WrtData  = 8'h00;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tick();
    tick();
    chk("rst_readdata", ReadData, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_halted",   halted,   1'b0);
    rst = 1'b0;
    tick();

    // RAM write then read with 1-cycle latency.
    bus(1'b1, 32'h0000_0100, 8'hAB);
    bus(1'b0, 32'h0000_0100, 8'h00);
    chk("ram_rd_lat1", ReadData, 8'hAB);
    tick();
    chk("ram_rd_hold", ReadData, 8'hAB);

    // Four TX pushes with the address toggling in between.
    bus(1'b1, 32'h0003_0000, 8'h11);
    bus(1'b0, 32'h0003_0001, 8'h00);
    bus(1'b1, 32'h0003_0000, 8'h22);
    bus(1'b0, 32'h0003_0001, 8'h00);
    bus(1'b1, 32'h0003_0000, 8'h33);
    bus(1'b0, 32'h0003_0001, 8'h00);
    bus(1'b1, 32'h0003_0000, 8'h44);
    bus(1'b0, 32'h0003_0001, 8'h00);
    chk("io_rd_other", ReadData, 8'h00);
    chk("tx_valid_4", tx_valid, 1'b1);
    tx_ready = 1'b1;
    chk("tx_d0", tx_data, 8'h11);
    tick();
    chk("tx_d1", tx_data, 8'h22);
    tick();
    chk("tx_d2", tx_data, 8'h33);
    tick();
    chk("tx_d3", tx_data, 8'h44);
    tick();
    chk("tx_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Nine pushes into an 8-deep TX FIFO: the ninth is dropped and flags overflow.
    for (int i = 0; i < 9; i++) begin
      bus(1'b1, 32'h0003_0000, 8'hA0 + 8'(i));
      bus(1'b0, 32'h0003_0001, 8'h00);
    end
    bus(1'b0, 32'h0003_0004, 8'h00);
    chk("status_ovf_full", ReadData, 8'h06);
    bus(1'b1, 32'h0003_0008, 8'h00);
    bus(1'b0, 32'h0003_0004, 8'h00);
    chk("status_clr", ReadData, 8'h02);
    tx_ready = 1'b1;
    chk("tx_ovf_first", tx_data, 8'hA0);
    repeat (7) tick();
    chk("tx_ovf_last", tx_data, 8'hA7);
    tick();
    chk("tx_ovf_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;
    tick();
    chk("status_all_clear", ReadData, 8'h00);

    // RX: held read pops exactly once.
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    tick();
    rx_data  = 8'h6B;
    tick();
    rx_valid = 1'b0;
    bus(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd0", ReadData, 8'h5A);
    tick();
    chk("rx_hold1", ReadData, 8'h5A);
    tick();
    chk("rx_hold2", ReadData, 8'h5A);
    bus(1'b0, 32'h0003_0004, 8'h00);
    chk("rx_one_pop_status", ReadData, 8'h01);
    bus(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd1", ReadData, 8'h6B);
    bus(1'b0, 32'h0003_0004, 8'h00);
    chk("rx_empty_status", ReadData, 8'h00);
    bus(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd_empty", ReadData, 8'h00);

    // Halt, then asynchronous reset in mid-cycle.
    bus(1'b1, 32'h0003_0000, 8'h77);
    bus(1'b1, 32'h0003_0004, 8'h00);
    chk("halted_set", halted, 1'b1);
    chk("tx_valid_pre_rst", tx_valid, 1'b1);
    bus(1'b0, 32'h0000_0100, 8'h00);
    chk("ram_rd_pre_rst", ReadData, 8'hAB);
    tick();
    chk("halted_sticky", halted, 1'b1);
    RWaddr = 32'h0003_0001;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_halted",   halted,   1'b0);
    chk("arst_readdata", ReadData, 8'h00);
    chk("arst_tx_valid", tx_valid, 1'b0);
    chk("arst_rx_ready", rx_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill RX, then a qualifying pop with rx_valid held high.
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'hC0 + 8'(i);
      tick();
    end
    chk("rx_full_ready", rx_ready, 1'b0);
    rx_data = 8'hD0;
    bus(1'b0, 32'h0003_0000, 8'h00);
    chk("rx_full_pop_oldest", ReadData, 8'hC0);
    chk("rx_ready_after_pop", rx_ready, 1'b1);
    bus(1'b0, 32'h0003_0001, 8'h00);
    chk("rx_refilled", rx_ready, 1'b0);
    rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 32'h0003_0000, 8'h00);
      chk($sformatf("rx_drain%0d", i), ReadData, (i < 7) ? (8'hC1 + 8'(i)) : 8'hD0);
      bus(1'b0, 32'h0003_0001, 8'h00);
    end
    bus(1'b0, 32'h0003_0004, 8'h00);
    chk("final_status", ReadData, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
